// File: rtl/head_table_pkg.sv
// Shared types for the head-table write path: FSM states and the
// registered write bundle driven onto the head-table RAM port.
package head_table_pkg;

  localparam int HT_A_WIDTH   = 8;
  localparam int HT_PTR_WIDTH = 10;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } ht_wr_arb_state_t;

  typedef struct packed {
    logic [HT_A_WIDTH-1:0]   addr;
    logic [HT_PTR_WIDTH-1:0] ptr;
    logic                    ptr_val;
  } head_table_wr_t;

endpackage

// File: rtl/head_table_if.sv
// Head-table RAM write port. The write arbiter is the only master.
interface head_table_if #(
  parameter int A_WIDTH        = 8,
  parameter int HEAD_PTR_WIDTH = 10
);

  logic [A_WIDTH-1:0]        wr_addr;
  logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr;
  logic                      wr_data_ptr_val;
  logic                      wr_en;

  modport master (
    output wr_addr,
    output wr_data_ptr,
    output wr_data_ptr_val,
    output wr_en
  );

  modport slave (
    input wr_addr,
    input wr_data_ptr,
    input wr_data_ptr_val,
    input wr_en
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; the search starts after the last
// granted index, which only moves on the advance strobe.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [IW-1:0] pick;
  logic          found;
  int            k;

  always_comb begin
    gnt_o = '0;
    pick  = last_q;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last_q) + i) % N;
      if (en_i && !found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        pick     = IW'(k);
        found    = 1'b1;
      end
    end
  end

  assign last_d = adv_i ? pick : last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/head_table_wr_arb.sv
// Head-table write-port arbiter with full-table clear sequencer.
// Define HEAD_TABLE_CLEAR_ON_RESET_EN to sweep the table after reset.
module head_table_wr_arb
  import head_table_pkg::*;
#(
  parameter int A_WIDTH        = HT_A_WIDTH,
  parameter int HEAD_PTR_WIDTH = HT_PTR_WIDTH,
  parameter int REQ_CNT        = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REQ_CNT-1:0]                req_valid_i,
  input  logic [REQ_CNT*A_WIDTH-1:0]        req_addr_i,
  input  logic [REQ_CNT*HEAD_PTR_WIDTH-1:0] req_ptr_i,
  input  logic [REQ_CNT-1:0]                req_ptr_val_i,
  output logic [REQ_CNT-1:0]                req_ready_o,
  input  logic                              clear_start_i,
  output logic                              clear_busy_o,
  head_table_if.master                      ht_if
);

`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
  localparam ht_wr_arb_state_t RST_STATE = CLEAR;
`else
  localparam ht_wr_arb_state_t RST_STATE = ARB;
`endif

  localparam logic [A_WIDTH:0] CNT_LAST = {1'b0, {A_WIDTH{1'b1}}};

  ht_wr_arb_state_t state_q, state_d;
  logic [A_WIDTH:0] cnt_q, cnt_d;
  head_table_wr_t   wr_q, wr_d;
  logic             wr_en_q, wr_en_d;

  logic [REQ_CNT-1:0] gnt;
  logic               arb_en;
  head_table_wr_t     sel;

  // clear has priority over any request in the start cycle
  assign arb_en = (state_q == ARB) & ~clear_start_i & ~rst_i;

  rr_arbiter #(
    .N (REQ_CNT)
  ) u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_valid_i),
    .en_i  (arb_en),
    .adv_i (|gnt),
    .gnt_o (gnt)
  );

  assign req_ready_o  = gnt;
  assign clear_busy_o = (state_q == CLEAR);

  always_comb begin
    sel = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (gnt[i]) begin
        sel.addr    |= req_addr_i[i*A_WIDTH +: A_WIDTH];
        sel.ptr     |= req_ptr_i[i*HEAD_PTR_WIDTH +: HEAD_PTR_WIDTH];
        sel.ptr_val |= req_ptr_val_i[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = '0;
    wr_en_d = 1'b0;
    unique case (state_q)
      ARB: begin
        if (clear_start_i) begin
          // address 0 goes out now, so the sweep continues from 1
          state_d = CLEAR;
          cnt_d   = (A_WIDTH+1)'(1);
          wr_en_d = 1'b1;
        end else if (|gnt) begin
          wr_en_d = 1'b1;
          wr_d    = sel;
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_d.addr = cnt_q[A_WIDTH-1:0];
        if (cnt_q == CNT_LAST) begin
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      wr_q    <= '0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign ht_if.wr_addr         = wr_q.addr;
  assign ht_if.wr_data_ptr     = wr_q.ptr;
  assign ht_if.wr_data_ptr_val = wr_q.ptr_val;
  assign ht_if.wr_en           = wr_en_q;

endmodule

// File: tb/tb_head_table_wr_arb.sv
// Bench for head_table_wr_arb: behavioural model of grants and clear
// sweeps, directed scenarios plus a randomized run.
module tb_head_table_wr_arb;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int PW = 10;
  localparam int DEPTH = 1 << AW;
`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
  localparam bit CLR_ON_RST = 1'b1;
`else
  localparam bit CLR_ON_RST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] valid = '0;
  logic [AW-1:0] ra [N];
  logic [PW-1:0] rp [N];
  logic rv [N];
  logic clear_start = 1'b0;
  logic [N*AW-1:0] addr_flat;
  logic [N*PW-1:0] ptr_flat;
  logic [N-1:0] pv_flat;
  logic [N-1:0] req_ready_o;
  logic clear_busy_o;

  int n_run = 0;
  int n_fail = 0;

  head_table_if #(.A_WIDTH(AW), .HEAD_PTR_WIDTH(PW)) ht ();

  assign addr_flat = {ra[1], ra[0]};
  assign ptr_flat  = {rp[1], rp[0]};
  assign pv_flat   = {rv[1], rv[0]};

  head_table_wr_arb #(
    .A_WIDTH(AW), .HEAD_PTR_WIDTH(PW), .REQ_CNT(N)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(valid),
    .req_addr_i(addr_flat),
    .req_ptr_i(ptr_flat),
    .req_ptr_val_i(pv_flat),
    .req_ready_o(req_ready_o),
    .clear_start_i(clear_start),
    .clear_busy_o(clear_busy_o),
    .ht_if(ht)
  );

  always #5 clk = ~clk;

  // model: last winner, clear writes still owed, expected output reg
  int m_last = N - 1;
  int clr_left = 0;
  int clr_addr = 0;
  bit m_en = 1'b0;
  bit m_rst = 1'b1;
  logic [AW-1:0] m_a = '0;
  logic [PW-1:0] m_p = '0;
  logic m_v = 1'b0;

  function automatic int pick();
    if (rst || clr_left > 0 || clear_start) return -1;
    for (int i = 1; i <= N; i++) begin
      if (valid[(m_last + i) % N]) return (m_last + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = pick();
    m_en = 1'b0; m_a = '0; m_p = '0; m_v = 1'b0;
    m_rst = rst;
    if (rst) begin
      m_last = N - 1;
      clr_left = CLR_ON_RST ? DEPTH : 0;
      clr_addr = 0;
    end else if (clr_left > 0) begin
      m_en = 1'b1; m_a = AW'(clr_addr);
      clr_addr++; clr_left--;
    end else if (clear_start) begin
      m_en = 1'b1; m_a = '0;
      clr_addr = 1; clr_left = DEPTH - 1;
    end else if (g >= 0) begin
      m_en = 1'b1; m_a = ra[g]; m_p = rp[g]; m_v = rv[g];
      m_last = g;
    end
  end

  function automatic logic [22:0] expv();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = pick();
    if (g >= 0) r[g] = 1'b1;
    return {r, clr_left > 0, m_en,
            (m_en | m_rst) ? {m_a, m_p, m_v} : 19'd0};
  endfunction

  function automatic logic [22:0] obsv();
    return {req_ready_o, clear_busy_o, ht.wr_en,
            (m_en | m_rst) ? {ht.wr_addr, ht.wr_data_ptr,
                              ht.wr_data_ptr_val} : 19'd0};
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); n_run++;
      if (obsv() !== expv() || ht.wr_en !== 1'b0 || ht.wr_addr !== '0
          || ht.wr_data_ptr !== '0 || req_ready_o !== '0) begin
        n_fail++;
        $display("FAIL reset c=%0d got=%h want=%h", c, obsv(), expv());
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; valid = '0;
    for (int c = 0; c < 300 && (clr_left > 0 || m_en); c++) begin
      @(negedge clk); n_run++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL reset_sweep c=%0d got=%h want=%h", c, obsv(), expv());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    valid = 2'b01; ra[0] = 8'h12; rp[0] = 10'h155; rv[0] = 1'b1;
    @(negedge clk); n_run++;
    if (obsv() !== expv() || req_ready_o !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready got=%b want=01", req_ready_o);
    end
    @(posedge clk); #1;
    valid = '0;
    @(negedge clk); n_run++;
    if (obsv() !== expv() || ht.wr_en !== 1'b1 || ht.wr_addr !== 8'h12
        || ht.wr_data_ptr !== 10'h155 || ht.wr_data_ptr_val !== 1'b1) begin
      n_fail++;
      $display("FAIL single_write got=%b/%h/%h/%b want=1/12/155/1",
               ht.wr_en, ht.wr_addr, ht.wr_data_ptr, ht.wr_data_ptr_val);
    end
    @(posedge clk); #1;
    @(negedge clk); n_run++;
    if (ht.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse got=%b want=0", ht.wr_en);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    logic [N-1:0] prev;
    int pulses;
    prev = '0; pulses = 0;
    valid = 2'b11;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) valid = '0;
      for (int i = 0; i < N; i++) begin
        ra[i] = AW'($urandom); rp[i] = PW'($urandom); rv[i] = 1'($urandom);
      end
      @(negedge clk); n_run++;
      if (obsv() !== expv() || (c < 6 && req_ready_o === prev)) begin
        n_fail++;
        $display("FAIL fair c=%0d got=%h want=%h", c, obsv(), expv());
      end
      prev = req_ready_o;
      if (ht.wr_en === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    n_run++;
    if (pulses != 6) begin
      n_fail++;
      $display("FAIL fair_pulses got=%0d want=6", pulses);
    end
  endtask

  task automatic test_clear();
    int acc, seq;
    acc = -1; seq = 0;
    valid = 2'b01; ra[0] = 8'h3c; rp[0] = 10'h2a5; rv[0] = 1'b1;
    clear_start = 1'b1;
    @(negedge clk); n_run++;
    if (obsv() !== expv() || req_ready_o !== '0) begin
      n_fail++;
      $display("FAIL clear_start got=%h want=%h", obsv(), expv());
    end
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int c = 1; c <= 300 && acc < 0; c++) begin
      @(negedge clk); n_run++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL clear_cyc c=%0d got=%h want=%h", c, obsv(), expv());
      end
      if (ht.wr_en === 1'b1 && ht.wr_addr === AW'(seq)
          && ht.wr_data_ptr === '0 && ht.wr_data_ptr_val === 1'b0
          && (c == DEPTH || clear_busy_o === 1'b1))
        seq++;
      if (req_ready_o[0] === 1'b1) acc = c;
      @(posedge clk); #1;
    end
    valid = '0;
    n_run++;
    if (seq != DEPTH || acc != DEPTH) begin
      n_fail++;
      $display("FAIL clear_sweep got=%0d/%0d want=%0d/%0d", seq, acc, DEPTH, DEPTH);
    end
  endtask

  task automatic test_mid_reset();
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    for (int c = 0; c < 300 && clr_addr != 100; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk); n_run++;
    if (obsv() !== expv() || ht.wr_addr !== 8'd99) begin
      n_fail++;
      $display("FAIL midrst_pre got=%h want=%h", obsv(), expv());
    end
    @(posedge clk); #1;
    rst = 1'b0; valid = 2'b01; ra[0] = 8'h77; rp[0] = 10'h001; rv[0] = 1'b1;
    @(negedge clk); n_run++;
    if (obsv() !== expv() || ht.wr_en !== 1'b0
        || clear_busy_o !== CLR_ON_RST
        || req_ready_o !== (CLR_ON_RST ? 2'b00 : 2'b01)) begin
      n_fail++;
      $display("FAIL midrst_post got=%h want=%h", obsv(), expv());
    end
    @(posedge clk); #1;
    valid = '0;
    for (int c = 0; c < 300 && (clr_left > 0 || m_en); c++) begin
      @(negedge clk); n_run++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL midrst_drain c=%0d got=%h want=%h", c, obsv(), expv());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_restart();
    int writes;
    writes = 0;
    clear_start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); n_run++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL restart c=%0d got=%h want=%h", c, obsv(), expv());
      end
      if (ht.wr_en === 1'b1) writes++;
      @(posedge clk); #1;
      clear_start = (clr_addr == 50);
      if (c > 2 && clr_left == 0 && !m_en) break;
    end
    clear_start = 1'b0;
    n_run++;
    if (writes != DEPTH) begin
      n_fail++;
      $display("FAIL restart_count got=%0d want=%0d", writes, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ra[i] = AW'($urandom); rp[i] = PW'($urandom); rv[i] = 1'($urandom);
      end
      clear_start = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk); n_run++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL random c=%0d got=%h want=%h", c, obsv(), expv());
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; clear_start = 1'b0; valid = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ra[i] = '0; rp[i] = '0; rv[i] = 1'b0;
    end
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_fairness();
    test_clear();
    test_mid_reset();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
